// File: rtl/data_mem_access.sv
// Load/store unit between the RV32I datapath and a word-wide data memory.
// Aligns store lanes and byte enables, extracts and extends load data, and aborts stalled accesses.
module data_mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fault_o,
   output logic [31:0] read_data_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lat_we;
   logic [2:0]       lat_f3;
   logic [1:0]       lat_off;

   logic [1:0]  off_c;
   logic        legal_c;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [15:0] lane_c;
   logic [31:0] load_val_c;

   // Request decode: legality (funct3 + alignment) and store lane placement
   always_comb begin
      off_c   = addr_i[1:0];
      legal_c = 1'b0;
      be_c    = 4'b1111;
      wdata_c = store_data_i;
      if (we_i) begin
         case (funct3_i)
            3'b000:  legal_c = 1'b1;
            3'b001:  legal_c = ~off_c[0];
            3'b010:  legal_c = (off_c == 2'b00);
            default: legal_c = 1'b0;
         endcase
         case (funct3_i[1:0])
            2'b00: begin
               be_c    = 4'b0001 << off_c;
               wdata_c = {4{store_data_i[7:0]}};
            end
            2'b01: begin
               be_c    = 4'b0011 << {off_c[1], 1'b0};
               wdata_c = {2{store_data_i[15:0]}};
            end
            default: begin
               be_c    = 4'b1111;
               wdata_c = store_data_i;
            end
         endcase
      end else begin
         case (funct3_i)
            3'b000, 3'b100: legal_c = 1'b1;
            3'b001, 3'b101: legal_c = ~off_c[0];
            3'b010:         legal_c = (off_c == 2'b00);
            default:        legal_c = 1'b0;
         endcase
      end
   end

   // Load extraction from the returned word
   always_comb begin
      lane_c = 16'(mem_rdata_i >> {lat_off, 3'b000});
      case (lat_f3)
         3'b000:  load_val_c = {{24{lane_c[7]}}, lane_c[7:0]};
         3'b100:  load_val_c = {24'd0, lane_c[7:0]};
         3'b001:  load_val_c = {{16{lane_c[15]}}, lane_c};
         3'b101:  load_val_c = {16'd0, lane_c};
         default: load_val_c = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         lat_we      <= 1'b0;
         lat_f3      <= 3'b000;
         lat_off     <= 2'b00;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'd0;
         mem_be_o    <= 4'd0;
         mem_wdata_o <= 32'd0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         fault_o     <= 1'b0;
         read_data_o <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  lat_we  <= we_i;
                  lat_f3  <= funct3_i;
                  lat_off <= off_c;
                  busy_o  <= 1'b1;
                  if (legal_c) begin
                     state       <= WAIT;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= we_i;
                     mem_addr_o  <= {addr_i[31:2], 2'b00};
                     mem_be_o    <= be_c;
                     mem_wdata_o <= wdata_c;
                  end else begin
                     state   <= DONE;
                     done_o  <= 1'b1;
                     fault_o <= 1'b1;
                     if (!we_i) read_data_o <= 32'd0;
                  end
               end
            end
            WAIT: begin
               // Ack takes priority over a timeout expiring in the same cycle
               if (mem_ack_i) begin
                  state     <= DONE;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  done_o    <= 1'b1;
                  fault_o   <= 1'b0;
                  if (!lat_we) read_data_o <= load_val_c;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state     <= DONE;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  done_o    <= 1'b1;
                  fault_o   <= 1'b1;
                  if (!lat_we) read_data_o <= 32'd0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state   <= IDLE;
               cnt     <= '0;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               fault_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: loads, stores, illegal accesses, timeout and reset abort.
module tb_data_mem_access;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] store_data_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;
   logic        done_o;
   logic        fault_o;
   logic [31:0] read_data_o;

   int n_checks = 0;
   int n_err    = 0;
   int req_cnt;
   int done_cnt;

   data_mem_access #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .we_i(we_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o),
      .fault_o(fault_o), .read_data_o(read_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns in the cycle after the sampling edge
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      we_i = we; funct3_i = f3; addr_i = a; store_data_i = d; start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic load_ok(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp);
      issue(1'b0, f3, a, 32'h0);
      chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
      mem_ack_i = 1'b1; mem_rdata_i = rdata;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      chk({tag, "_done"}, {30'd0, done_o, fault_o}, 32'd2);
      chk({tag, "_data"}, read_data_o, exp);
      tick();
   endtask

   task automatic store_ok(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
      issue(1'b1, f3, a, d);
      chk({tag, "_req_we"}, {30'd0, mem_req_o, mem_we_o}, 32'd3);
      chk({tag, "_addr"}, mem_addr_o, exp_addr);
      chk({tag, "_be"}, 32'(mem_be_o), 32'(exp_be));
      chk({tag, "_wdata"}, mem_wdata_o, exp_wd);
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      chk({tag, "_done"}, {30'd0, done_o, fault_o}, 32'd2);
      chk({tag, "_rd_kept"}, read_data_o, exp_rd);
      tick();
   endtask

   task automatic illegal(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] exp_rd);
      issue(we, f3, a, 32'hFFFF_FFFF);
      chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
      chk({tag, "_done_fault"}, {30'd0, done_o, fault_o}, 32'd3);
      chk({tag, "_rd"}, read_data_o, exp_rd);
      tick();
      chk({tag, "_idle"}, {30'd0, busy_o, mem_req_o}, 32'd0);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
      addr_i = 32'h0; store_data_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      tick(); tick();
      rst_i = 1'b0;
      chk("rst_ctrl", {28'd0, busy_o, done_o, fault_o, mem_req_o}, 32'd0);
      chk("rst_rd", read_data_o, 32'd0);
      chk("rst_be", 32'(mem_be_o), 32'd0);

      // LW with ack on first request cycle: done two cycles after start
      issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
      chk("lw_req", {29'd0, mem_req_o, mem_we_o, busy_o}, 32'd5);
      chk("lw_addr", mem_addr_o, 32'h0000_0100);
      chk("lw_be", 32'(mem_be_o), 32'hF);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      tick();
      mem_ack_i = 1'b0;
      chk("lw_done", {29'd0, done_o, fault_o, mem_req_o}, 32'd4);
      chk("lw_data", read_data_o, 32'hDEAD_BEEF);
      tick();
      chk("lw_idle", {30'd0, busy_o, done_o}, 32'd0);

      load_ok("lb",  3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
      load_ok("lbu", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080);
      load_ok("lh",  3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF);
      load_ok("lhu", 3'b101, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF);
      load_ok("lb0", 3'b000, 32'h0000_0100, 32'h80FF_1234, 32'h0000_0034);

      store_ok("sb", 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0000_0200, 4'b0010,
               32'hABAB_ABAB, 32'h0000_0034);
      store_ok("sh", 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0000_0200, 4'b1100,
               32'h1234_1234, 32'h0000_0034);
      store_ok("sw", 3'b010, 32'h0000_0204, 32'h0102_0304, 32'h0000_0204, 4'b1111,
               32'h0102_0304, 32'h0000_0034);

      illegal("sh_mis", 1'b1, 3'b001, 32'h0000_0101, 32'h0000_0034);
      illegal("lw_mis", 1'b0, 3'b010, 32'h0000_0102, 32'h0000_0000);
      load_ok("lw2", 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h1234_5678);
      illegal("ld_f3", 1'b0, 3'b011, 32'h0000_0100, 32'h0000_0000);
      illegal("st_f3", 1'b1, 3'b100, 32'h0000_0100, 32'h0000_0000);

      // Timeout: request held exactly 16 cycles, then faulting done
      load_ok("lw3", 3'b010, 32'h0000_0100, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
      issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
      req_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req_o) req_cnt++;
         if (done_o) break;
         tick();
      end
      chk("to_req_cycles", 32'(req_cnt), 32'd16);
      chk("to_done_fault", {30'd0, done_o, fault_o}, 32'd3);
      chk("to_rd", read_data_o, 32'd0);
      tick();

      // Ack on the 16th request cycle wins over the timeout
      issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
      for (int i = 0; i < 15; i++) tick();
      chk("to16_req", 32'(mem_req_o), 32'd1);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
      tick();
      mem_ack_i = 1'b0;
      chk("to16_done", {30'd0, done_o, fault_o}, 32'd2);
      chk("to16_data", read_data_o, 32'hCAFE_F00D);
      tick();

      // Reset during WAIT aborts with no done pulse
      issue(1'b0, 3'b010, 32'h0000_0108, 32'h0);
      chk("rstw_req", 32'(mem_req_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rstw_abort", {29'd0, mem_req_o, busy_o, done_o}, 32'd0);
      tick();
      chk("rstw_no_done", {30'd0, done_o, busy_o}, 32'd0);

      // start_i during WAIT is ignored: exactly one done pulse
      done_cnt = 0;
      issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
      start_i = 1'b1; addr_i = 32'h0000_0400;
      tick();
      start_i = 1'b0;
      chk("busy_start_addr", mem_addr_o, 32'h0000_0100);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
      tick();
      mem_ack_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done_o) done_cnt++;
         tick();
      end
      chk("busy_start_dones", 32'(done_cnt), 32'd1);
      chk("busy_start_idle", {30'd0, busy_o, mem_req_o}, 32'd0);
      chk("busy_start_data", read_data_o, 32'h0BAD_F00D);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
